traffic_sensor_unit: RTL and testbench
======================================

TRAFFIC_SENSOR_UNIT -- requirements
Module: traffic_sensor_unit

Interface
REQ-001 The block SHALL have parameter DEB, default 3, giving the number of consecutive equal samples needed to accept a detector level change (range 2..15).
REQ-002 The block SHALL have parameter DEP, default 4, giving the number of green cycles per vehicle departure (range 1..15).
REQ-003 The block SHALL have parameter QW, default 4, giving the queue counter width; the maximum queue value is 2^QW-1.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port det_a, input, 1 bit: raw vehicle detector for street A; may bounce.
REQ-007 Port det_b, input, 1 bit: raw vehicle detector for street B; may bounce.
REQ-008 Port la, input, 2 bits: street A light code, 00 green, 01 yellow, 10 red, 11 illegal.
REQ-009 Port lb, input, 2 bits: street B light code, same encoding as la.
REQ-010 Port ta, output, 1 bit: traffic present on A, feeding the controller TA input.
REQ-011 Port tb, output, 1 bit: traffic present on B, feeding the controller TB input.
REQ-012 Port queue_a, output, QW bits: vehicles waiting on A.
REQ-013 Port queue_b, output, QW bits: vehicles waiting on B.
REQ-014 Port ovf, output, 2 bits: sticky queue overflow flags; bit0 is A, bit1 is B.
REQ-015 Port conflict, output, 1 bit: sticky light-safety violation.

Function
REQ-016 Each detector SHALL be filtered by its own state machine, with states IDLE (filtered level 0), RISE, HIGH (filtered level 1) and FALL.
- IDLE: a raw 1 moves to RISE.
- RISE: a raw 0 returns to IDLE; DEB consecutive 1 samples, counted from the first, move to HIGH.
- HIGH: a raw 0 moves to FALL.
- FALL: a raw 1 returns to HIGH; DEB consecutive 0 samples move to IDLE.
REQ-017 Each entry into HIGH SHALL produce exactly one arrival event, on the same edge that samples the DEB-th consecutive 1.
REQ-018 An arrival event SHALL increment the street's queue on that same edge, so the new queue value is visible immediately after it.
REQ-019 Departure timing SHALL depend on the street's light code:
- While the code is 00 and the queue is nonzero, the departure timer SHALL increment each cycle.
- When the timer reaches DEP-1, the queue SHALL decrement and the timer SHALL return to 0.
- When the code is not 00, or the queue is 0, the timer SHALL be cleared to 0.
REQ-020 No departures SHALL occur while the light code is 01 (yellow).
REQ-021 If an arrival and a departure fall on the same edge, the queue SHALL be unchanged and the timer SHALL still return to 0.
REQ-022 An arrival while the queue is at 2^QW-1 SHALL leave the queue saturated and SHALL set the corresponding ovf bit; the queue SHALL never wrap.
REQ-023 The queue SHALL never decrement below 0.
REQ-024 ta SHALL equal (queue_a != 0) and tb SHALL equal (queue_b != 0), decoded from the registered queues with no added latency.
REQ-025 conflict SHALL be set on any edge where (la != 10 and lb != 10), or la == 11, or lb == 11.
REQ-026 Once set, conflict and ovf bits SHALL remain set until reset.
REQ-027 Streams A and B SHALL operate fully independently, except for the shared conflict check.

Reset
REQ-028 While rst is sampled high, both filters SHALL return to IDLE with their counters at 0, and both departure timers SHALL be 0.
REQ-029 While rst is sampled high, queue_a, queue_b, ta, tb, ovf and conflict SHALL all be 0.
REQ-030 A reset asserted mid-filter or mid-departure SHALL discard the partial count; no arrival or departure SHALL be generated on the reset edge.
REQ-031 After rst deasserts, a detector already held high SHALL require DEB fresh samples before it is counted.

Structure
REQ-032 A shared package traffic_pkg SHALL hold the light-code constants (GREEN=00, YELLOW=01, RED=10, ILLEGAL=11), the filter state encoding, and the DEB/DEP/QW defaults.
REQ-033 The detector filter SHALL be a single sub-module, sensor_debounce (ports clk, rst, raw, level, rise_pulse), instantiated twice.
REQ-034 The queue and departure logic SHALL stay inline, one instance per street.

Verification
REQ-035 Debounce: det_a toggles 1,0,1,1,0 on successive cycles, then holds 1 for 3 cycles -> exactly one arrival; queue_a=1 and ta=1 on the third high edge.
REQ-036 Departure: queue_b=3, lb=00 held for 12 cycles -> queue_b steps 2,1,0 at cycles 4, 8 and 12; tb falls with the final step; no further change afterwards.
REQ-037 Yellow and simultaneity: queue_a=2, la=01 held for 10 cycles -> no departures; then la=00 with an arrival landing on the 4th green edge -> queue_a stays 2 and the timer restarts.
REQ-038 Overflow: 16 arrivals on A with la=10 -> queue_a saturates at 15 and ovf=01; the ovf bit persists after queue_a drains.
REQ-039 Safety: la=00 and lb=01 for one cycle -> conflict=1 on that edge and held; separately, la=11 -> conflict=1.
REQ-040 Reset mid-operation: rst pulsed for one cycle while det_b is in RISE and the A timer is at 2 -> all outputs 0; det_b held high needs 3 new samples to count.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, debounce state encoding and default sizing shared by
// the traffic sensor block and its detector filter.
package traffic_pkg;
    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;
    localparam int DEB_DEF = 3;
    localparam int DEP_DEF = 4;
    localparam int QW_DEF  = 4;
    typedef enum logic [1:0] {S_IDLE, S_RISE, S_HIGH, S_FALL} deb_state_t;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: four-state detector filter; rise_pulse fires combinationally on
// the edge that samples the DEB-th consecutive high so the arrival lands on that edge.
module sensor_debounce import traffic_pkg::*; #(
    parameter int DEB = DEB_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);
    deb_state_t r_state;
    logic [3:0] r_cnt;
    logic       w_done;
    assign w_done     = r_cnt == 4'(DEB - 1);
    assign level      = r_state == S_HIGH || r_state == S_FALL;
    assign rise_pulse = !rst && r_state == S_RISE && raw && w_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (raw) begin r_state <= S_RISE; r_cnt <= 4'd1; end
                S_RISE: if (!raw) begin r_state <= S_IDLE; r_cnt <= '0; end
                        else if (w_done) begin r_state <= S_HIGH; r_cnt <= '0; end
                        else r_cnt <= r_cnt + 4'd1;
                S_HIGH: if (!raw) begin r_state <= S_FALL; r_cnt <= 4'd1; end
                S_FALL: if (raw) begin r_state <= S_HIGH; r_cnt <= '0; end
                        else if (w_done) begin r_state <= S_IDLE; r_cnt <= '0; end
                        else r_cnt <= r_cnt + 4'd1;
            endcase
        end
    end
endmodule

// File: rtl/traffic_sensor_unit.sv
// traffic_sensor_unit: debounced vehicle queues per street with green-time departures,
// sticky overflow flags and a sticky light-safety conflict flag.
module traffic_sensor_unit import traffic_pkg::*; #(
    parameter int DEB = DEB_DEF,
    parameter int DEP = DEP_DEF,
    parameter int QW  = QW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          det_a,
    input  logic          det_b,
    input  logic [1:0]    la,
    input  logic [1:0]    lb,
    output logic          ta,
    output logic          tb,
    output logic [QW-1:0] queue_a,
    output logic [QW-1:0] queue_b,
    output logic [1:0]    ovf,
    output logic          conflict
);
    logic [1:0]          w_det, w_arr, w_level, w_ovf;
    logic [1:0][1:0]     w_light;
    logic [1:0][QW-1:0]  w_queue;
    logic                r_conflict;
    assign w_det   = {det_b, det_a};
    assign w_light = {lb, la};
    for (genvar s = 0; s < 2; s++) begin : g_st
        logic [QW-1:0] r_queue;
        logic [3:0]    r_timer;
        logic          r_ovf;
        logic          w_dep, w_full;
        sensor_debounce #(.DEB(DEB)) u_deb (
            .clk        (clk),
            .rst        (rst),
            .raw        (w_det[s]),
            .level      (w_level[s]),
            .rise_pulse (w_arr[s])
        );
        assign w_full = &r_queue;
        assign w_dep  = w_light[s] == GREEN && r_queue != '0 && r_timer == 4'(DEP - 1);
        // simultaneous arrival and departure cancel; the timer still restarts
        always_ff @(posedge clk) begin
            if (rst) begin
                r_queue <= '0;
                r_timer <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_timer <= (w_light[s] != GREEN || r_queue == '0 || w_dep) ? '0 : r_timer + 4'd1;
                r_queue <= (w_arr[s] && !w_dep && !w_full) ? r_queue + 1'b1 :
                           (w_dep && !w_arr[s]) ? r_queue - 1'b1 : r_queue;
                r_ovf   <= r_ovf | (w_arr[s] && !w_dep && w_full);
            end
        end
        assign w_queue[s] = r_queue;
        assign w_ovf[s]   = r_ovf;
    end
    always_ff @(posedge clk) begin
        if (rst) r_conflict <= 1'b0;
        else r_conflict <= r_conflict | (la != RED && lb != RED) | (la == ILLEGAL) | (lb == ILLEGAL);
    end
    assign queue_a  = w_queue[0];
    assign queue_b  = w_queue[1];
    assign ta       = queue_a != '0;
    assign tb       = queue_b != '0;
    assign ovf      = w_ovf;
    assign conflict = r_conflict;
endmodule

// File: tb/tb_traffic_sensor_unit.sv
// tb_traffic_sensor_unit: directed stimulus pushes hand-computed expectations into a
// queue; a monitor pops one per clock and compares every output.
module tb_traffic_sensor_unit;
    import traffic_pkg::*;
    typedef struct {
        int         qa;
        int         qb;
        logic [1:0] ov;
        logic       cf;
    } exp_t;
    logic       clk = 0, rst, det_a, det_b, ta, tb, conflict;
    logic [1:0] la, lb, ovf;
    logic [3:0] queue_a, queue_b;
    exp_t       exp_q[$];
    int         n_chk = 0, n_fail = 0;
    int         eqa, eqb;
    logic [1:0] eovf;
    logic       ecf;
    logic       seq [8] = '{1, 0, 1, 1, 0, 1, 1, 1};

    traffic_sensor_unit dut (
        .clk(clk), .rst(rst), .det_a(det_a), .det_b(det_b), .la(la), .lb(lb),
        .ta(ta), .tb(tb), .queue_a(queue_a), .queue_b(queue_b), .ovf(ovf), .conflict(conflict)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("queue_a", int'(queue_a), e.qa);
                chk("queue_b", int'(queue_b), e.qb);
                chk("ta", int'(ta), int'(e.qa != 0));
                chk("tb", int'(tb), int'(e.qb != 0));
                chk("ovf", int'(ovf), int'(e.ov));
                chk("conflict", int'(conflict), int'(e.cf));
            end
        end
    end

    task automatic cyc(input logic r, input logic da, input logic db, input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        rst = r; det_a = da; det_b = db; la = a; lb = b;
        exp_q.push_back('{eqa, eqb, eovf, ecf});
    endtask

    task automatic vehicle_a();
        cyc(0, 1, 0, RED, RED);
        cyc(0, 1, 0, RED, RED);
        if (eqa == 15) eovf[0] = 1'b1;
        else eqa++;
        cyc(0, 1, 0, RED, RED);
        repeat (3) cyc(0, 0, 0, RED, RED);
    endtask

    task automatic vehicle_b();
        cyc(0, 0, 1, RED, RED);
        cyc(0, 0, 1, RED, RED);
        eqb++;
        cyc(0, 0, 1, RED, RED);
        repeat (3) cyc(0, 0, 0, RED, RED);
    endtask

    initial begin
        rst = 1; det_a = 0; det_b = 0; la = RED; lb = RED;
        eqa = 0; eqb = 0; eovf = 2'b00; ecf = 0;
        cyc(1, 0, 0, RED, RED);
        cyc(1, 0, 0, RED, RED);
        // bouncing detector A: one arrival on the third consecutive high
        for (int i = 0; i < 8; i++) begin
            if (i == 7) eqa = 1;
            cyc(0, seq[i], 0, RED, RED);
        end
        repeat (2) cyc(0, 1, 0, RED, RED);
        repeat (3) cyc(0, 0, 0, RED, RED);
        // B departures every 4 green cycles
        repeat (3) vehicle_b();
        for (int k = 1; k <= 12; k++) begin
            if (k % 4 == 0) eqb--;
            cyc(0, 0, 0, RED, GREEN);
        end
        repeat (3) cyc(0, 0, 0, RED, GREEN);
        // yellow holds queue, then arrival coincides with departure
        vehicle_a();
        repeat (10) cyc(0, 0, 0, YELLOW, RED);
        cyc(0, 0, 0, GREEN, RED);
        repeat (3) cyc(0, 1, 0, GREEN, RED);
        repeat (3) cyc(0, 0, 0, GREEN, RED);
        eqa = 1;
        cyc(0, 0, 0, GREEN, RED);
        cyc(0, 0, 0, RED, RED);
        // overflow from empty
        eqa = 0; eqb = 0;
        cyc(1, 0, 0, RED, RED);
        repeat (16) vehicle_a();
        for (int k = 1; k <= 60; k++) begin
            if (k % 4 == 0) eqa--;
            cyc(0, 0, 0, GREEN, RED);
        end
        repeat (2) cyc(0, 0, 0, GREEN, RED);
        // safety conflicts
        ecf = 1;
        cyc(0, 0, 0, GREEN, YELLOW);
        repeat (2) cyc(0, 0, 0, RED, RED);
        eovf = 2'b00; ecf = 0;
        cyc(1, 0, 0, RED, RED);
        ecf = 1;
        cyc(0, 0, 0, ILLEGAL, RED);
        cyc(0, 0, 0, RED, RED);
        // reset with det_b mid-rise and A timer at 2
        ecf = 0;
        cyc(1, 0, 0, RED, RED);
        vehicle_a();
        repeat (2) cyc(0, 0, 1, GREEN, RED);
        eqa = 0;
        cyc(1, 0, 1, GREEN, RED);
        repeat (2) cyc(0, 0, 1, GREEN, RED);
        eqb = 1;
        cyc(0, 0, 1, GREEN, RED);
        cyc(0, 0, 1, GREEN, RED);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
